// File: rtl/rd_image_scaler_if.sv
// rd_image_scaler_if: pixel-path bundle between the display timing generator,
// the external image ROM, the image reader and the HDMI encoder input.
//
// Signals:
//   frame_start  one-cycle pulse, restart the scan at pixel (0,0)
//   rd_req       one pixel request per high cycle
//   rom_addr     ROM address presented by the reader
//   rom_dout     ROM read data, ROM_LAT clocks after the address is sampled
//   rd_data      pixel to the encoder, BG colour while rd_valid is low
//   rd_valid     rd_data qualifier
//   frame_done   one-cycle pulse after the last request of an output frame
//
// Handshake: rd_req is a strobe with no backpressure. Every high cycle is
// accepted and produces exactly one rd_valid cycle a fixed latency later,
// in request order. rd_data is meaningful only while rd_valid is high.
//
// Modports:
//   slave   the reader (rd_image_scaler)
//   master  the environment: timing generator, ROM and encoder side
interface rd_image_scaler_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
);
  logic              frame_start;
  logic              rd_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_done;

  modport slave (
    input  frame_start, rd_req, rom_dout,
    output rom_addr, rd_data, rd_valid, frame_done
  );

  modport master (
    output frame_start, rd_req, rom_dout,
    input  rom_addr, rd_data, rd_valid, frame_done
  );
endinterface

// File: rtl/rd_image_scaler.sv
// rd_image_scaler: streams an IMG_W x IMG_H image out of a synchronous ROM,
// one pixel per rd_req, with integer pixel replication (SCALE_X) and line
// repetition (SCALE_Y). rd_data/rd_valid appear ROM_LAT+1 clocks after the
// request. frame_start restarts the scan; frame_done marks the end of an
// output frame.
//
// Ports:
//   clk  pixel clock
//   rst  asynchronous, active-low reset
//   bus  rd_image_scaler_if.slave (frame_start, rd_req, rom_dout in;
//        rom_addr, rd_data, rd_valid, frame_done out)
module rd_image_scaler #(
  parameter int              IMG_W    = 256,
  parameter int              IMG_H    = 256,
  parameter int              DATA_W   = 24,
  parameter int              ADDR_W   = 16,
  parameter int              SCALE_X  = 1,
  parameter int              SCALE_Y  = 1,
  parameter int              ROM_LAT  = 1,
  parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
  input logic               clk,
  input logic               rst,
  rd_image_scaler_if.slave  bus
);

  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [SXW-1:0]    SX_MAX   = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0]    SY_MAX   = SYW'(SCALE_Y - 1);
  localparam logic [CW-1:0]     COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [SXW-1:0]    sub_x, sub_x_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic [SYW-1:0]    sub_y, sub_y_nxt;
  logic [RW-1:0]     row, row_nxt;
  logic [ADDR_W-1:0] row_base, row_base_nxt;
  logic              done_nxt;

  logic [ROM_LAT-1:0] vpipe;
  logic [DATA_W-1:0]  rd_data_q;
  logic               rd_valid_q;
  logic               frame_done_q;

  // frame_start forces the origin combinationally, so a request in the same
  // cycle reads pixel (0,0) and the counters step from there.
  assign bus.rom_addr = bus.frame_start ? '0 : (row_base + ADDR_W'(col));

  always_comb begin
    sub_x_nxt    = bus.frame_start ? '0 : sub_x;
    col_nxt      = bus.frame_start ? '0 : col;
    sub_y_nxt    = bus.frame_start ? '0 : sub_y;
    row_nxt      = bus.frame_start ? '0 : row;
    row_base_nxt = bus.frame_start ? '0 : row_base;
    done_nxt     = 1'b0;
    if (bus.rd_req) begin
      if (sub_x_nxt != SX_MAX) begin
        sub_x_nxt = sub_x_nxt + SXW'(1);
      end else begin
        sub_x_nxt = '0;
        if (col_nxt != COL_MAX) begin
          col_nxt = col_nxt + CW'(1);
        end else begin
          // End of a line: row_base is held so the line repeats SCALE_Y times.
          col_nxt = '0;
          if (sub_y_nxt != SY_MAX) begin
            sub_y_nxt = sub_y_nxt + SYW'(1);
          end else begin
            sub_y_nxt = '0;
            if (row_nxt != ROW_MAX) begin
              row_nxt      = row_nxt + RW'(1);
              row_base_nxt = row_base_nxt + ROW_STEP;
            end else begin
              row_nxt      = '0;
              row_base_nxt = '0;
              // A restart in the same cycle owns the frame boundary.
              done_nxt     = !bus.frame_start;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_x        <= '0;
      col          <= '0;
      sub_y        <= '0;
      row          <= '0;
      row_base     <= '0;
      frame_done_q <= 1'b0;
      vpipe        <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= BG_COLOR;
    end else begin
      sub_x        <= sub_x_nxt;
      col          <= col_nxt;
      sub_y        <= sub_y_nxt;
      row          <= row_nxt;
      row_base     <= row_base_nxt;
      frame_done_q <= done_nxt;
      // vpipe[i] marks a request issued i+1 clocks ago; the last stage lines
      // up with rom_dout, and the output register adds the final clock.
      vpipe[0]     <= bus.rd_req;
      for (int i = 1; i < ROM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      rd_valid_q   <= vpipe[ROM_LAT-1];
      rd_data_q    <= vpipe[ROM_LAT-1] ? bus.rom_dout : BG_COLOR;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
